// File: rtl/bitorder_pkg.sv
// bitorder_pkg: shared types for the beat reorder FIFO.
// Holds default geometry, FSM state encodings and the queued entry.
package bitorder_pkg;

  localparam int BO_IN_W   = 2;
  localparam int BO_WORD_W = 8;
  localparam int BO_DEPTH  = 4;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_FILL,
    IN_DISCARD
  } in_state_t;

  typedef enum logic {
    OUT_IDLE,
    OUT_SHIFT
  } out_state_t;

  typedef struct packed {
    logic [BO_WORD_W-1:0] word;
    logic                 last;
    logic                 err;
    logic                 ord;
  } entry_t;

endpackage

// File: rtl/bitorder_fifo_word_fifo.sv
// word_fifo: DEPTH-entry queue of packed words with frame flags.
// mark tags the newest stored entry as a truncated frame end.
module word_fifo
  import bitorder_pkg::*;
#(
  parameter int DEPTH = BO_DEPTH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  input  logic   mark,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW:0]     wp_q;
  logic [AW:0]     rp_q;
  logic [AW-1:0]   newest;

  assign empty  = (wp_q == rp_q);
  assign full   = (wp_q[AW] != rp_q[AW]) &&
                  (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout   = mem[rp_q[AW-1:0]];
  assign newest = wp_q[AW-1:0] - 1'b1;

  // Pointer advance; the extra MSB separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
    end
  end

  // Storage writes and end-of-frame tagging of the newest entry.
  always_ff @(posedge clk) begin
    if (push) mem[wp_q[AW-1:0]] <= din;
    if (mark) begin
      mem[newest].last <= 1'b1;
      mem[newest].err  <= 1'b1;
    end
  end

endmodule

// File: rtl/bitorder_fifo.sv
// bitorder_fifo: packs LSB-first beats into words, queues, re-serialises.
// BITORDER_PARTIAL_FLUSH_EN: pad and emit a trailing partial word.
module bitorder_fifo
  import bitorder_pkg::*;
#(
  parameter int IN_W   = BO_IN_W,
  parameter int WORD_W = BO_WORD_W,
  parameter int DEPTH  = BO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            axiiv,
  input  logic [IN_W-1:0] axiid,
  input  logic            ord_sel,
  input  logic            axior,
  output logic            axiov,
  output logic [IN_W-1:0] axiod,
  output logic            axiolast,
  output logic            axioerr,
  output logic            ovf
);

  localparam int BEATS = WORD_W / IN_W;
  localparam int CW    = (BEATS > 2) ? $clog2(BEATS) : 1;

  in_state_t         is_q, is_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ord_q, ord_d;
  logic [WORD_W-1:0] pend_q, pend_d;
  logic              pv_q, pv_d;
  logic              ovf_q, ovf_d;
  logic              push, push_ok, push_last, mark;
  entry_t            wr_e;

  out_state_t        os_q, os_d;
  entry_t            sh_q, sh_d;
  logic [CW-1:0]     bc_q, bc_d;
  logic              pop, fin;

  entry_t            rd_e;
  logic              full, empty;

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .din   (wr_e),
    .pop   (pop),
    .mark  (mark),
    .dout  (rd_e),
    .full  (full),
    .empty (empty)
  );

  // Input side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_q   <= IN_IDLE;
      acc_q  <= '0;
      cnt_q  <= '0;
      ord_q  <= 1'b0;
      pend_q <= '0;
      pv_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      is_q   <= is_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ord_q  <= ord_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      ovf_q  <= ovf_d;
    end
  end

  // Packing FSM; a word is held back so its last flag is known at push.
  always_comb begin
    is_d      = is_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ord_d     = ord_q;
    pend_d    = pend_q;
    pv_d      = pv_q;
    ovf_d     = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    mark      = 1'b0;
    unique case (is_q)
      IN_IDLE: begin
        if (pv_q) begin
          push      = 1'b1;
          push_last = 1'b1;
          pv_d      = 1'b0;
        end
        if (axiiv) begin
          ord_d            = ord_sel;
          acc_d            = '0;
          acc_d[IN_W-1:0]  = axiid;
          cnt_d            = CW'(1);
          is_d             = IN_FILL;
        end
      end
      IN_FILL: begin
        if (axiiv) begin
          for (int k = 0; k < BEATS; k++)
            if (cnt_q == CW'(k))
              acc_d[k*IN_W +: IN_W] = axiid;
          if (cnt_q == CW'(BEATS-1)) begin
            push   = pv_q;
            pend_d = acc_d;
            pv_d   = 1'b1;
            acc_d  = '0;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          is_d  = IN_IDLE;
          acc_d = '0;
          cnt_d = '0;
          if (pv_q) begin
            push = 1'b1;
`ifdef BITORDER_PARTIAL_FLUSH_EN
            if (cnt_q != '0) begin
              pend_d = acc_q;
              pv_d   = 1'b1;
            end else begin
              push_last = 1'b1;
              pv_d      = 1'b0;
            end
`else
            push_last = 1'b1;
            pv_d      = 1'b0;
`endif
          end
        end
      end
      IN_DISCARD: begin
        acc_d = '0;
        cnt_d = '0;
        if (!axiiv) is_d = IN_IDLE;
      end
      default: is_d = IN_IDLE;
    endcase
    push_ok = push;
    if (push && full && !pop) begin
      push_ok = 1'b0;
      mark    = 1'b1;
      ovf_d   = 1'b1;
      pv_d    = 1'b0;
      if (is_q == IN_FILL && axiiv) is_d = IN_DISCARD;
    end
    wr_e      = '0;
    wr_e.word = pend_q;
    wr_e.last = push_last;
    wr_e.ord  = ord_q;
  end

  // Output side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_q <= OUT_IDLE;
      sh_q <= '0;
      bc_q <= '0;
    end else begin
      os_q <= os_d;
      sh_q <= sh_d;
      bc_q <= bc_d;
    end
  end

  // Serialiser FSM; beats advance only on an accepted transfer.
  always_comb begin
    os_d     = os_q;
    sh_d     = sh_q;
    bc_d     = bc_q;
    pop      = 1'b0;
    fin      = (bc_q == CW'(BEATS-1));
    axiov    = (os_q == OUT_SHIFT);
    axiod    = '0;
    for (int k = 0; k < BEATS; k++)
      if (bc_q == CW'(sh_q.ord ? BEATS-1-k : k))
        axiod = sh_q.word[k*IN_W +: IN_W];
    axiolast = axiov && fin && sh_q.last;
    axioerr  = axiov && fin && sh_q.err;
    ovf      = ovf_q;
    unique case (os_q)
      OUT_IDLE: begin
        if (!empty) begin
          pop  = 1'b1;
          sh_d = rd_e;
          bc_d = '0;
          os_d = OUT_SHIFT;
        end
      end
      OUT_SHIFT: begin
        if (axior) begin
          if (fin) begin
            if (!empty) begin
              pop  = 1'b1;
              sh_d = rd_e;
              bc_d = '0;
            end else begin
              os_d = OUT_IDLE;
            end
          end else begin
            bc_d = bc_q + 1'b1;
          end
        end
      end
      default: os_d = OUT_IDLE;
    endcase
  end

endmodule
